// File: rtl/dcache_coherence_agent.sv
// Cache-side coherence bus agent: turns block requests into ccif bus transactions and answers snoops.
// Optional snoop statistics counters are enabled with `define DCACHE_AGENT_CNT_EN.
module dcache_coherence_agent #(
   parameter int BLK_WORDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] wb_data0,
   input  logic [31:0] wb_data1,
   output logic        req_done,
   output logic [31:0] fill_data0,
   output logic [31:0] fill_data1,
   output logic [31:0] snp_lookup_addr,
   input  logic        snp_hit,
   input  logic        snp_dirty,
   input  logic [31:0] snp_data0,
   input  logic [31:0] snp_data1,
   output logic        snp_inv,
   output logic        snp_downgrade,
   output logic        dREN,
   output logic        dWEN,
   output logic        cctrans,
   output logic        ccwrite,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dwait,
   input  logic [31:0] dload,
   input  logic        ccwait,
   input  logic        ccinv,
   input  logic [31:0] ccsnoopaddr
`ifdef DCACHE_AGENT_CNT_EN
   ,
   output logic [15:0] snoop_hit_cnt,
   output logic [15:0] snoop_supply_cnt
`endif
);

   generate
      if (BLK_WORDS != 2) begin : g_bad_blk_words
         $error("dcache_coherence_agent supports only BLK_WORDS == 2");
      end
   endgenerate

   typedef enum logic [3:0] {
      IDLE, RD0, RD1, WB0, WB1, SNP_LOOK, SNP_S0, SNP_S1, SNP_END, DONE
   } state_t;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic        trans;
      logic        write;
      logic [31:0] addr;
      logic [31:0] store;
   } bus_t;

   state_t      state;
   bus_t        bus;
   logic        excl;
   logic        done_pend;
   logic        inv_q;
   logic [31:0] base;
   logic [31:0] snp_d0;
   logic [31:0] snp_d1;

   // Bus lines for the state being entered, so every output leaves a flop.
   function automatic bus_t bus_for(input state_t st, input logic excl_in,
                                    input logic [31:0] a, input logic [31:0] d0,
                                    input logic [31:0] d1);
      bus_t b;
      b = '0;
      case (st)
         RD0: begin
            b.ren   = 1'b1;
            b.trans = 1'b1;
            b.write = excl_in;
            b.addr  = a;
         end
         RD1: begin
            b.ren   = 1'b1;
            b.trans = 1'b1;
            b.write = excl_in;
            b.addr  = a + 32'd4;
         end
         WB0: begin
            b.wen   = 1'b1;
            b.addr  = a;
            b.store = d0;
         end
         WB1: begin
            b.wen   = 1'b1;
            b.addr  = a + 32'd4;
            b.store = d1;
         end
         SNP_LOOK: b.trans = 1'b1;
         SNP_S0: begin
            b.trans = 1'b1;
            b.write = 1'b1;
            b.addr  = a;
            b.store = d0;
         end
         SNP_S1: begin
            b.trans = 1'b1;
            b.write = 1'b1;
            b.addr  = a + 32'd4;
            b.store = d1;
         end
         default: b = '0;
      endcase
      return b;
   endfunction

   assign dREN    = bus.ren;
   assign dWEN    = bus.wen;
   assign cctrans = bus.trans;
   assign daddr   = bus.addr;
   assign dstore  = bus.store;
   // The supply intent follows the same-cycle tag lookup while in SNP_LOOK.
   assign ccwrite = bus.write | ((state == SNP_LOOK) & snp_hit & snp_dirty);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state           <= IDLE;
         bus             <= '0;
         req_done        <= 1'b0;
         fill_data0      <= '0;
         fill_data1      <= '0;
         snp_lookup_addr <= '0;
         snp_inv         <= 1'b0;
         snp_downgrade   <= 1'b0;
         excl            <= 1'b0;
         done_pend       <= 1'b0;
         inv_q           <= 1'b0;
         base            <= '0;
         snp_d0          <= '0;
         snp_d1          <= '0;
      end else begin
         req_done      <= 1'b0;
         snp_inv       <= 1'b0;
         snp_downgrade <= 1'b0;
         case (state)
            IDLE: begin
               if (ccwait) begin
                  state           <= SNP_LOOK;
                  snp_lookup_addr <= ccsnoopaddr;
                  inv_q           <= ccinv;
                  bus             <= bus_for(SNP_LOOK, 1'b0, '0, '0, '0);
               end else if (req_valid && req_op != 2'b11) begin
                  base <= req_addr;
                  excl <= (req_op == 2'b01);
                  if (req_op == 2'b10) begin
                     state <= WB0;
                     bus   <= bus_for(WB0, 1'b0, req_addr, wb_data0, wb_data1);
                  end else begin
                     state <= RD0;
                     bus   <= bus_for(RD0, req_op[0], req_addr, '0, '0);
                  end
               end
            end
            RD0: begin
               // A snoop before the first word lands abandons the read; IDLE re-issues it.
               if (ccwait) begin
                  state           <= SNP_LOOK;
                  snp_lookup_addr <= ccsnoopaddr;
                  inv_q           <= ccinv;
                  bus             <= bus_for(SNP_LOOK, 1'b0, '0, '0, '0);
               end else if (!dwait) begin
                  fill_data0 <= dload;
                  state      <= RD1;
                  bus        <= bus_for(RD1, excl, base, '0, '0);
               end
            end
            RD1: begin
               if (!dwait) begin
                  fill_data1 <= dload;
                  state      <= DONE;
                  done_pend  <= 1'b0;
                  bus        <= '0;
               end
            end
            WB0: begin
               if (!dwait) begin
                  state <= WB1;
                  bus   <= bus_for(WB1, 1'b0, base, wb_data0, wb_data1);
               end
            end
            WB1: begin
               if (!dwait) begin
                  state     <= DONE;
                  done_pend <= 1'b0;
                  bus       <= '0;
               end
            end
            DONE: begin
               // One quiet bus cycle first, then the completion pulse, then IDLE.
               if (!done_pend) begin
                  req_done  <= 1'b1;
                  done_pend <= 1'b1;
               end else begin
                  done_pend <= 1'b0;
                  state     <= IDLE;
               end
            end
            SNP_LOOK: begin
               snp_d0 <= snp_data0;
               snp_d1 <= snp_data1;
               if (snp_hit && snp_dirty) begin
                  state <= SNP_S0;
                  bus   <= bus_for(SNP_S0, 1'b1, snp_lookup_addr, snp_data0, snp_data1);
               end else begin
                  state   <= SNP_END;
                  bus     <= '0;
                  snp_inv <= snp_hit & inv_q;
               end
            end
            SNP_S0: begin
               if (!dwait) begin
                  state <= SNP_S1;
                  bus   <= bus_for(SNP_S1, 1'b1, snp_lookup_addr, snp_d0, snp_d1);
               end
            end
            SNP_S1: begin
               if (!dwait) begin
                  state         <= SNP_END;
                  bus           <= '0;
                  snp_inv       <= inv_q;
                  snp_downgrade <= ~inv_q;
               end
            end
            SNP_END: begin
               if (!ccwait) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               bus   <= '0;
            end
         endcase
      end
   end

`ifdef DCACHE_AGENT_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         snoop_hit_cnt    <= '0;
         snoop_supply_cnt <= '0;
      end else if (state == SNP_LOOK) begin
         if (snp_hit && snoop_hit_cnt != 16'hFFFF)
            snoop_hit_cnt <= snoop_hit_cnt + 16'd1;
         if (snp_hit && snp_dirty && snoop_supply_cnt != 16'hFFFF)
            snoop_supply_cnt <= snoop_supply_cnt + 16'd1;
      end
   end
`endif

endmodule
